// File: rtl/bcd_arith_scan_n.sv
`default_nettype none
// bcd_arith_scan_n: add/subtract two unsigned operands, double-dabble the magnitude to BCD, scan a 7-seg display.
// Optional macro LEADING_ZERO_BLANK_EN blanks digit positions above the most significant nonzero digit.
module bcd_arith_scan_n #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  selector_suma_resta,
  input  logic [WIDTH-1:0]      input_top_1,
  input  logic [WIDTH-1:0]      input_top_2,
  output logic [6:0]            SSeg,
  output logic [DIGITS:0]       an,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic                  overflow,
  output logic                  done
);

  localparam int MW   = WIDTH + 1;
  localparam int NEED = (MW * 30103 + 99999) / 100000 + 1;
  localparam int ND   = (NEED > DIGITS) ? NEED : DIGITS;
  localparam int BW   = 4 * ND;
  localparam int CW   = $clog2(MW + 1);
  localparam int RW   = $clog2(REFRESH_DIV);
  localparam int IW   = $clog2(DIGITS + 1);
  localparam int AW   = DIGITS + 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [MW-1:0]       mag_q;
  logic [BW-1:0]       bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;
  logic [4*DIGITS-1:0] bcd_out_q;
  logic                neg_out_q;
  logic                ovf_q;
  logic                done_q;

  logic [RW-1:0]       ref_q;
  logic [IW-1:0]       idx_q;
  logic [AW-1:0]       an_q;
  logic [6:0]          sseg_q;

  logic [MW-1:0]       load_mag_d;
  logic                load_neg_d;
  logic [BW-1:0]       adj_d;
  logic [BW-1:0]       bcd_d;
  logic [MW-1:0]       mag_d;
  logic                ovf_d;
  logic [3:0]          nib_d;
  logic [6:0]          seg_d;

  always_comb begin
    load_neg_d = 1'b0;
    if (!selector_suma_resta) begin
      load_mag_d = {1'b0, input_top_1} + {1'b0, input_top_2};
    end else if (input_top_1 >= input_top_2) begin
      load_mag_d = {1'b0, input_top_1 - input_top_2};
    end else begin
      load_mag_d = {1'b0, input_top_2 - input_top_1};
      load_neg_d = 1'b1;
    end
  end

  // One double-dabble step: correct every nibble >=5, then shift {bcd, mag} left.
  always_comb begin
    adj_d = bcd_q;
    for (int k = 0; k < ND; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        adj_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    {bcd_d, mag_d} = {adj_d, mag_q} << 1;
  end

  if (ND > DIGITS) begin : g_ovf
    assign ovf_d = |bcd_d[BW-1:4*DIGITS];
  end else begin : g_no_ovf
    assign ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      bcd_out_q <= '0;
      neg_out_q <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: state_q <= S_LOAD;
        S_LOAD: begin
          mag_q   <= load_mag_d;
          neg_q   <= load_neg_d;
          bcd_q   <= '0;
          cnt_q   <= CW'(MW);
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q - CW'(1);
          // Display registers are loaded with the final step so they are valid throughout DONE.
          if (cnt_q == CW'(1)) begin
            bcd_out_q <= bcd_d[4*DIGITS-1:0];
            neg_out_q <= neg_q;
            ovf_q     <= ovf_d;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_LOAD;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    case (v)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = SEG_BLANK;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_d;
  logic              all0_d;

  always_comb begin
    lz_d   = '0;
    all0_d = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all0_d = all0_d & (bcd_out_q[4*k +: 4] == 4'd0);
      lz_d[k] = all0_d;
    end
  end
`endif

  always_comb begin
    nib_d = '0;
    seg_d = SEG_BLANK;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib_d = bcd_out_q[4*k +: 4];
      end
    end
    if (idx_q == IW'(DIGITS)) begin
      seg_d = neg_out_q ? SEG_DASH : SEG_BLANK;
    end else if (ovf_q) begin
      seg_d = SEG_DASH;
    end else begin
      seg_d = seg_dec(nib_d);
`ifdef LEADING_ZERO_BLANK_EN
      for (int k = 1; k < DIGITS; k++) begin
        if (idx_q == IW'(k) && lz_d[k]) begin
          seg_d = SEG_BLANK;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      sseg_q <= SEG_BLANK;
    end else begin
      an_q   <= ~(AW'(1) << idx_q);
      sseg_q <= seg_d;
      if (ref_q == RW'(REFRESH_DIV - 1)) begin
        ref_q <= '0;
        idx_q <= (idx_q == IW'(DIGITS)) ? '0 : idx_q + IW'(1);
      end else begin
        ref_q <= ref_q + RW'(1);
      end
    end
  end

  assign SSeg     = sseg_q;
  assign an       = an_q;
  assign bcd_out  = bcd_out_q;
  assign negative = neg_out_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_arith_scan_n.sv
`default_nettype none
// Scoreboard bench for bcd_arith_scan_n: a 3-digit instance and a 2-digit instance for overflow.
`timescale 1ns/1ps
module tb_bcd_arith_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic [7:0]  a, b;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        neg, ovf, done;

  logic        rst2, sel2;
  logic [7:0]  a2, b2;
  logic [6:0]  sseg2;
  logic [2:0]  an2;
  logic [7:0]  bcd2;
  logic        neg2, ovf2, done2;

  bcd_arith_scan_n #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(rst), .selector_suma_resta(sel),
    .input_top_1(a), .input_top_2(b),
    .SSeg(sseg), .an(an), .bcd_out(bcd),
    .negative(neg), .overflow(ovf), .done(done)
  );

  bcd_arith_scan_n #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) dut2 (
    .clk(clk), .reset(rst2), .selector_suma_resta(sel2),
    .input_top_1(a2), .input_top_2(b2),
    .SSeg(sseg2), .an(an2), .bcd_out(bcd2),
    .negative(neg2), .overflow(ovf2), .done(done2)
  );

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse while the queue holds one.
  int last_done = -1;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        last_done = -1;
      end else if (done) begin
        if (last_done >= 0) chk("done_spacing", cyc - last_done, 11);
        last_done = cyc;
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("bcd_out", bcd, e.bcd);
          chk("negative", neg, e.neg);
          chk("overflow", ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst2 && done2 && q2.size() > 0) begin
        e = q2.pop_front();
        chk("bcd_out2", bcd2, e.bcd[7:0]);
        chk("negative2", neg2, e.neg);
        chk("overflow2", ovf2, e.ovf);
      end
    end
  end

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_done2();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done2) begin ok = 1; break; end
    end
    if (!ok) chk("done2_timeout", 0, 1);
  endtask

  // Called just after a done: new operands go in during DONE, LOAD samples them next.
  task automatic issue(input logic s, input logic [7:0] x, input logic [7:0] y,
                       input logic [11:0] eb, input logic en, input logic eo);
    @(negedge clk);
    sel = s; a = x; b = y;
    q1.push_back('{bcd: eb, neg: en, ovf: eo});
    wait_done();
  endtask

  task automatic seg_at_an(input logic [3:0] want_an, input logic [6:0] want_seg, input string name);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (an == want_an) begin ok = 1; break; end
    end
    if (ok) chk(name, sseg, want_seg);
    else    chk({name, "_an_timeout"}, 0, 1);
  endtask

  task automatic seg_at_an2(input logic [2:0] want_an, input logic [6:0] want_seg, input string name);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (an2 == want_an) begin ok = 1; break; end
    end
    if (ok) chk(name, sseg2, want_seg);
    else    chk({name, "_an_timeout"}, 0, 1);
  endtask

  function automatic logic [6:0] exp_seg_510(input logic [3:0] p);
    case (p)
      4'b1110: exp_seg_510 = 7'b1000000;
      4'b1101: exp_seg_510 = 7'b1111001;
      4'b1011: exp_seg_510 = 7'b0010010;
      default: exp_seg_510 = 7'b1111111;
    endcase
  endfunction

  initial begin
    int         lat;
    int         run;
    logic [3:0] prev;
    rst = 1'b1; sel = 1'b0; a = 8'd0; b = 8'd0;
    rst2 = 1'b1; sel2 = 1'b0; a2 = 8'd0; b2 = 8'd0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_sseg", sseg, 7'h7F);
      chk("rst_an", an, 4'b1111);
      chk("rst_bcd", bcd, 12'h000);
      chk("rst_neg", neg, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_done", done, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    chk("first_done_latency", lat, 11);

    issue(1'b0, 8'd255, 8'd255, 12'h510, 1'b0, 1'b0);
    issue(1'b1, 8'd150, 8'd45,  12'h105, 1'b0, 1'b0);
    issue(1'b1, 8'd50,  8'd255, 12'h205, 1'b1, 1'b0);
    seg_at_an(4'b0111, 7'b0111111, "sign_dash");
    issue(1'b1, 8'd7,   8'd7,   12'h000, 1'b0, 1'b0);
    issue(1'b1, 8'd3,   8'd10,  12'h007, 1'b1, 1'b0);

    // Operands change mid-SHIFT; the in-flight conversion keeps the earlier LOAD.
    @(negedge clk);
    sel = 1'b0; a = 8'd200; b = 8'd55;
    q1.push_back('{bcd: 12'h255, neg: 1'b0, ovf: 1'b0});
    repeat (3) @(negedge clk);
    a = 8'd100; b = 8'd1;
    q1.push_back('{bcd: 12'h101, neg: 1'b0, ovf: 1'b0});
    wait_done();
    wait_done();

    issue(1'b0, 8'd255, 8'd255, 12'h510, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    prev = 4'b0000;
    run  = -1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      chk("scan_sseg", sseg, exp_seg_510(an));
      if (an != prev) begin
        if (prev != 4'b0000) chk("scan_order", an, {prev[2:0], prev[3]});
        if (run > 0) chk("scan_dwell", run, 4);
        run  = (prev == 4'b0000) ? -1 : 1;
        prev = an;
      end else if (run > 0) begin
        run = run + 1;
      end
    end

    // Two-digit instance: overflow display, then reset during SHIFT.
    @(negedge clk);
    rst2 = 1'b0;
    wait_done2();
    @(negedge clk);
    sel2 = 1'b0; a2 = 8'd99; b2 = 8'd1;
    q2.push_back('{bcd: 12'h000, neg: 1'b0, ovf: 1'b1});
    wait_done2();
    seg_at_an2(3'b110, 7'b0111111, "ovf_dash_units");
    seg_at_an2(3'b101, 7'b0111111, "ovf_dash_tens");
    seg_at_an2(3'b011, 7'b1111111, "ovf_sign_blank");
    wait_done2();
    repeat (3) @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("rst2_sseg", sseg2, 7'h7F);
    chk("rst2_an", an2, 3'b111);
    chk("rst2_bcd", bcd2, 8'h00);
    chk("rst2_neg", neg2, 1'b0);
    chk("rst2_ovf", ovf2, 1'b0);
    chk("rst2_done", done2, 1'b0);
    @(negedge clk);
    rst2 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done2) begin lat = i; break; end
    end
    chk("rst2_first_done_latency", lat, 11);
    chk("ovf_after_rst2", ovf2, 1'b1);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
